hazard_longop_scoreboard: RTL and testbench

//   Producer-side companion to the EX-stage RAW forwarding unit. Tracks destination

---
 rtl/hazard_longop_scoreboard.sv | 94 +++++++++
 tb/tb_hazard_longop_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_longop_scoreboard.sv
// Long-latency producer scoreboard for the decode stage.
// Tracks the destination registers of in-flight DIV/REM and non-forwardable
// loads. It stalls decode on a RAW or WAW hazard against a pending rd, or when
// the in-flight limit is reached. An entry is released when its result arrives
// on the completion port.
module hazard_longop_scoreboard #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid_d,
    input  logic                kill_d,
    input  logic [4:0]          rs1_d,
    input  logic [4:0]          rs2_d,
    input  logic                use_rs1_d,
    input  logic                use_rs2_d,
    input  logic [4:0]          rd_d,
    input  logic                regwrite_d,
    input  logic                long_op_d,
    input  logic                cmpl_valid,
    input  logic [4:0]          cmpl_rd,
    output logic                stall_d,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    pending_count,
    output logic                proto_err
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;

    logic [NUM_REGS-1:0] cmpl_hit;
    logic [NUM_REGS-1:0] eff_busy;
    logic [NUM_REGS-1:0] set_vec;
    logic                cmpl_dec;
    logic                raw, waw, full;
    logic                accept, set_en;
    logic [CNT_W-1:0]    count_after_cmpl;

    // Hazard detection against the pending mask.
    // A register that completes this cycle is treated as free.
    always_comb begin
        cmpl_hit = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            cmpl_hit[r] = cmpl_valid && (cmpl_rd == 5'(r));
        end
        eff_busy = busy_q & ~cmpl_hit;

        cmpl_dec         = cmpl_valid && (cmpl_rd != 5'd0) && busy_q[cmpl_rd];
        count_after_cmpl = count_q - CNT_W'(cmpl_dec);

        raw  = issue_valid_d &&
               ((use_rs1_d && eff_busy[rs1_d]) || (use_rs2_d && eff_busy[rs2_d]));
        waw  = issue_valid_d && regwrite_d && (rd_d != 5'd0) && eff_busy[rd_d];
        full = issue_valid_d && regwrite_d && long_op_d && (rd_d != 5'd0) &&
               (count_after_cmpl == CNT_W'(MAX_PENDING));

        stall_d = (raw || waw || full) && !kill_d;
        accept  = issue_valid_d && !kill_d && !stall_d;
        set_en  = accept && regwrite_d && long_op_d && (rd_d != 5'd0);
    end

    // Next-state computation. The set is OR-ed in after the clear, so a
    // register that is re-issued in the same cycle stays pending.
    always_comb begin
        set_vec = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            set_vec[r] = set_en && (rd_d == 5'(r));
        end
        busy_d  = (busy_q & ~cmpl_hit) | set_vec;
        count_d = count_q + CNT_W'(set_en) - CNT_W'(cmpl_dec);
        err_d   = err_q || (cmpl_valid && ((cmpl_rd == 5'd0) || !busy_q[cmpl_rd]));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign busy_vec      = busy_q;
    assign pending_count = count_q;
    assign proto_err     = err_q;

endmodule

// File: tb/tb_hazard_longop_scoreboard.sv
// Directed, table-driven bench for hazard_longop_scoreboard.
// Each row gives the inputs for one cycle, the stall expected in that cycle,
// and the registered state expected after the following clock edge.
module tb_hazard_longop_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid_d, kill_d;
    logic [4:0]  rs1_d, rs2_d, rd_d, cmpl_rd;
    logic        use_rs1_d, use_rs2_d, regwrite_d, long_op_d, cmpl_valid;
    logic        stall_d;
    logic [31:0] busy_vec;
    logic [2:0]  pending_count;
    logic        proto_err;

    int checks;
    int errors;

    hazard_longop_scoreboard #(
        .NUM_REGS(32),
        .MAX_PENDING(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .issue_valid_d(issue_valid_d),
        .kill_d(kill_d),
        .rs1_d(rs1_d),
        .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d),
        .use_rs2_d(use_rs2_d),
        .rd_d(rd_d),
        .regwrite_d(regwrite_d),
        .long_op_d(long_op_d),
        .cmpl_valid(cmpl_valid),
        .cmpl_rd(cmpl_rd),
        .stall_d(stall_d),
        .busy_vec(busy_vec),
        .pending_count(pending_count),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic        kill;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        lng;
        logic        cv;
        logic [4:0]  crd;
        logic        e_stall;
        logic [31:0] e_busy;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic rst, input logic iv, input logic kill,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw,
                       input logic lng, input logic cv, input logic [4:0] crd,
                       input logic es, input logic [31:0] eb, input logic [2:0] ec,
                       input logic ee);
        vec_t v;
        v.name = n; v.rst = rst; v.iv = iv; v.kill = kill;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.lng = lng; v.cv = cv; v.crd = crd;
        v.e_stall = es; v.e_busy = eb; v.e_cnt = ec; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        issue_valid_d = v.iv;
        kill_d        = v.kill;
        rs1_d         = v.rs1;
        use_rs1_d     = v.u1;
        rs2_d         = v.rs2;
        use_rs2_d     = v.u2;
        rd_d          = v.rd;
        regwrite_d    = v.rw;
        long_op_d     = v.lng;
        cmpl_valid    = v.cv;
        cmpl_rd       = v.crd;
    endtask

    // Called just after a rising edge: drive, check stall mid-cycle,
    // then check the registered state just after the next edge.
    task automatic apply(input vec_t v);
        drive(v);
        #3;
        chk({v.name, ".stall"}, {31'd0, stall_d}, {31'd0, v.e_stall});
        @(posedge clk);
        #1;
        chk({v.name, ".busy"}, busy_vec, v.e_busy);
        chk({v.name, ".cnt"}, {29'd0, pending_count}, {29'd0, v.e_cnt});
        chk({v.name, ".err"}, {31'd0, proto_err}, {31'd0, v.e_err});
    endtask

    vec_t hv;
    bit   released;

    initial begin
        checks = 0;
        errors = 0;

        //   name        rst iv kl rs1 u1 rs2 u2 rd rw lg cv crd  stall busy        cnt err
        add("reset",      1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 32'h0,       0, 0);
        add("t1_div5",    0, 1, 0,  1, 1,  2, 1,  5, 1, 1, 0,  0,  0, 32'h20,      1, 0);
        add("t1_add_a",   0, 1, 0,  5, 1,  1, 1,  6, 1, 0, 0,  0,  1, 32'h20,      1, 0);
        add("t1_add_b",   0, 1, 0,  5, 1,  1, 1,  6, 1, 0, 0,  0,  1, 32'h20,      1, 0);
        add("t1_add_cm",  0, 1, 0,  5, 1,  1, 1,  6, 1, 0, 1,  5,  0, 32'h0,       0, 0);
        add("t2_iss7",    0, 1, 0,  0, 0,  0, 0,  7, 1, 1, 0,  0,  0, 32'h80,      1, 0);
        add("t2_reiss7",  0, 1, 0,  0, 0,  0, 0,  7, 1, 1, 1,  7,  0, 32'h80,      1, 0);
        add("t2_cm7",     0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  7,  0, 32'h0,       0, 0);
        add("t3_x1",      0, 1, 0,  0, 0,  0, 0,  1, 1, 1, 0,  0,  0, 32'h2,       1, 0);
        add("t3_x2",      0, 1, 0,  0, 0,  0, 0,  2, 1, 1, 0,  0,  0, 32'h6,       2, 0);
        add("t3_x3",      0, 1, 0,  0, 0,  0, 0,  3, 1, 1, 0,  0,  0, 32'hE,       3, 0);
        add("t3_x4",      0, 1, 0,  0, 0,  0, 0,  4, 1, 1, 0,  0,  0, 32'h1E,      4, 0);
        add("t3_full",    0, 1, 0,  0, 0,  0, 0,  8, 1, 1, 0,  0,  1, 32'h1E,      4, 0);
        add("t3_full_cm", 0, 1, 0,  0, 0,  0, 0,  8, 1, 1, 1,  2,  0, 32'h11A,     4, 0);
        add("t3_addi",    0, 1, 0,  0, 0,  0, 0, 10, 1, 0, 0,  0,  0, 32'h11A,     4, 0);
        add("t3_cm1",     0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  1,  0, 32'h118,     3, 0);
        add("t3_cm3",     0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  3,  0, 32'h110,     2, 0);
        add("t3_cm4",     0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  4,  0, 32'h100,     1, 0);
        add("t3_cm8",     0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  8,  0, 32'h0,       0, 0);
        add("t4_x9",      0, 1, 0,  0, 0,  0, 0,  9, 1, 1, 0,  0,  0, 32'h200,     1, 0);
        add("t4_waw",     0, 1, 0,  0, 1,  0, 0,  9, 1, 0, 0,  0,  1, 32'h200,     1, 0);
        add("t4_waw_kill",0, 1, 1,  0, 1,  0, 0,  9, 1, 0, 0,  0,  0, 32'h200,     1, 0);
        add("t4_kill_lng",0, 1, 1,  0, 0,  0, 0, 13, 1, 1, 0,  0,  0, 32'h200,     1, 0);
        add("t4_x0_long", 0, 1, 0,  0, 0,  0, 0,  0, 1, 1, 0,  0,  0, 32'h200,     1, 0);
        add("t4_cm9",     0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  9,  0, 32'h0,       0, 0);
        add("t5_bad12",   0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1, 12,  0, 32'h0,       0, 1);
        add("t5_rst",     1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 32'h0,       0, 0);
        add("t5_bad0",    0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  0,  0, 32'h0,       0, 1);
        add("t5_sticky",  0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 32'h0,       0, 1);
        add("t6_x1",      0, 1, 0,  0, 0,  0, 0,  1, 1, 1, 0,  0,  0, 32'h2,       1, 1);
        add("t6_x2",      0, 1, 0,  0, 0,  0, 0,  2, 1, 1, 0,  0,  0, 32'h6,       2, 1);
        add("t6_x3",      0, 1, 0,  0, 0,  0, 0,  3, 1, 1, 0,  0,  0, 32'hE,       3, 1);
        add("t6_rst",     1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 32'h0,       0, 0);
        add("t6_rd_x1",   0, 1, 0,  1, 1,  0, 0,  0, 0, 0, 0,  0,  0, 32'h0,       0, 0);
        add("rs2_x11",    0, 1, 0,  0, 0,  0, 0, 11, 1, 1, 0,  0,  0, 32'h800,     1, 0);
        add("rs2_unused", 0, 1, 0,  3, 1, 11, 0,  0, 0, 0, 0,  0,  0, 32'h800,     1, 0);
        add("rs2_used",   0, 1, 0,  3, 1, 11, 1,  0, 0, 0, 0,  0,  1, 32'h800,     1, 0);
        add("rs2_cm11",   0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 1, 11,  0, 32'h0,       0, 0);

        hv = vecs[0];
        drive(hv);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Hand sequence: a dependent ADD waits on x5 until completion arrives
        // three cycles later; the completing cycle itself must not stall.
        hv = vecs[1];
        drive(hv);
        @(posedge clk);
        #1;
        hv = vecs[2];
        drive(hv);
        released = 1'b0;
        for (int c = 0; c < 10 && !released; c++) begin
            cmpl_valid = (c == 3);
            cmpl_rd    = 5'd5;
            #3;
            chk($sformatf("seq_wait.c%0d", c), {31'd0, stall_d}, {31'd0, (c != 3)});
            released = !stall_d;
            @(posedge clk);
            #1;
        end
        if (!released) begin
            checks++;
            errors++;
            $display("FAIL seq_wait.timeout actual=stalled required=released");
        end
        chk("seq_wait.busy", busy_vec, 32'h0);
        chk("seq_wait.cnt", {29'd0, pending_count}, 32'd0);

        // Hand sequence: at the limit, an x0 completion does not free a slot.
        for (int r = 1; r <= 4; r++) begin
            hv = vecs[9];
            hv.rd = 5'(r);
            drive(hv);
            @(posedge clk);
            #1;
        end
        chk("seq_full.cnt4", {29'd0, pending_count}, 32'd4);
        hv = vecs[12];
        hv.cv  = 1'b1;
        hv.crd = 5'd0;
        drive(hv);
        #3;
        chk("seq_full.x0cm_stall", {31'd0, stall_d}, 32'd1);
        @(posedge clk);
        #1;
        chk("seq_full.x0cm_cnt", {29'd0, pending_count}, 32'd4);
        chk("seq_full.x0cm_busy", busy_vec, 32'h1E);
        chk("seq_full.x0cm_err", {31'd0, proto_err}, 32'd1);

        hv = vecs[0];
        drive(hv);
        @(posedge clk);
        #1;
        chk("final_rst.busy", busy_vec, 32'h0);
        chk("final_rst.cnt", {29'd0, pending_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
